// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous-FIFO write port among NUM_REQ
// requesters; a grant lasts until last, MAX_BURST beats, or a stall timeout.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 8,
  parameter int IDX_WIDTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ-1:0]       req_last_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic                     fifo_full_i,
  output logic                     fifo_wr_en_o,
  output logic [WIDTH-1:0]         fifo_wdata_o,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic                     busy_o,
  output logic                     abort_o
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t               state;
  logic [IDX_WIDTH-1:0] rr_ptr;
  logic [IDX_WIDTH-1:0] owner;
  logic [3:0]           beat_cnt;
  logic [3:0]           stall_cnt;

  logic [IDX_WIDTH-1:0] pick;
  logic [IDX_WIDTH-1:0] next_ptr;
  logic                 found;
  logic                 own_valid;
  logic                 own_last;
  logic                 beat;
  logic                 stall_expired;
  int                   idx;

  // First valid requester starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        pick  = IDX_WIDTH'(idx);
      end
    end
  end

  assign next_ptr      = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;
  assign own_valid     = req_valid_i[owner];
  assign own_last      = req_last_i[owner];
  // Handshake: a beat moves when the owner's valid and ready are both high;
  // ready is simply ~fifo_full_i for the owner, so wr_en can never hit a full FIFO.
  assign beat          = (state == BURST) && own_valid && !fifo_full_i;
  assign stall_expired = (stall_cnt == 4'(TIMEOUT - 1));

  always_comb begin
    req_ready_o  = '0;
    fifo_wr_en_o = 1'b0;
    fifo_wdata_o = '0;
    grant_o      = '0;
    busy_o       = 1'b0;
    abort_o      = 1'b0;
    if (state == BURST) begin
      busy_o              = 1'b1;
      grant_o[owner]      = 1'b1;
      req_ready_o[owner]  = !fifo_full_i;
      fifo_wr_en_o        = beat;
      if (beat) fifo_wdata_o = req_data_i[int'(owner)*WIDTH +: WIDTH];
      abort_o             = !own_valid && stall_expired;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner     <= pick;
            beat_cnt  <= '0;
            stall_cnt <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (beat) begin
            stall_cnt <= '0;
            if (own_last || beat_cnt == 4'(MAX_BURST - 1)) begin
              state    <= IDLE;
              rr_ptr   <= next_ptr;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end else if (!own_valid) begin
            // Backpressure with valid data holds stall_cnt; only absence counts.
            if (stall_expired) begin
              state     <= IDLE;
              rr_ptr    <= next_ptr;
              stall_cnt <= '0;
            end else begin
              stall_cnt <= stall_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-requester beat queues drive the inputs and a
// cycle model (owner index, -1 when idle) predicts every output.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;
  localparam int TIMEOUT   = 8;
  localparam int IDX_WIDTH = 2;
  localparam int VW        = 2 * NUM_REQ + WIDTH + 3;

  logic                     clk_i = 1'b0;
  logic                     rst_ni = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_last = '0;
  logic [NUM_REQ*WIDTH-1:0] req_data = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full = 1'b0;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_wdata;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic                     abort;

  int checks = 0;
  int failures = 0;

  logic [WIDTH:0]       src_q [NUM_REQ][$];
  logic [NUM_REQ-1:0]   gap = '0;
  logic [WIDTH-1:0]     exp_q[$];
  logic [WIDTH-1:0]     wr_log[$];
  int                   abort_seen = 0;

  // Reference model state
  int m_owner = -1, m_ptr = 0, m_beats = 0, m_stalls = 0, m_xfer = -1;
  int n_owner, n_ptr, n_beats, n_stalls, n_xfer;
  logic [NUM_REQ-1:0] e_ready, e_grant;
  logic               e_wr, e_busy, e_abort;
  logic [WIDTH-1:0]   e_wdata;

  logic [VW-1:0] act_vec, exp_vec;
  assign act_vec = {req_ready, fifo_wr_en, fifo_wdata, grant, busy, abort};
  assign exp_vec = {e_ready, e_wr, e_wdata, e_grant, e_busy, e_abort};

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST),
    .TIMEOUT(TIMEOUT), .IDX_WIDTH(IDX_WIDTH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_last_i(req_last), .req_data_i(req_data),
    .req_ready_o(req_ready), .fifo_full_i(fifo_full),
    .fifo_wr_en_o(fifo_wr_en), .fifo_wdata_o(fifo_wdata),
    .grant_o(grant), .busy_o(busy), .abort_o(abort)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  // Model: outputs and next state from the arbitration rules.
  always_comb begin
    e_ready = '0; e_wr = 1'b0; e_wdata = '0; e_grant = '0; e_busy = 1'b0; e_abort = 1'b0;
    n_owner = m_owner; n_ptr = m_ptr; n_beats = m_beats; n_stalls = m_stalls; n_xfer = -1;
    if (m_owner < 0) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (n_owner < 0 && req_valid[(m_ptr + i) % NUM_REQ]) n_owner = (m_ptr + i) % NUM_REQ;
      n_beats = 0;
      n_stalls = 0;
    end else begin
      e_busy = 1'b1;
      e_grant[m_owner] = 1'b1;
      e_ready[m_owner] = !fifo_full;
      e_wr = req_valid[m_owner] && !fifo_full;
      if (e_wr) begin
        e_wdata = req_data[m_owner*WIDTH +: WIDTH];
        n_xfer = m_owner;
        n_beats = m_beats + 1;
        n_stalls = 0;
        if (req_last[m_owner] || n_beats == MAX_BURST) begin
          n_owner = -1;
          n_ptr = (m_owner + 1) % NUM_REQ;
        end
      end else if (!req_valid[m_owner]) begin
        n_stalls = m_stalls + 1;
        if (n_stalls == TIMEOUT) begin
          e_abort = 1'b1;
          n_owner = -1;
          n_ptr = (m_owner + 1) % NUM_REQ;
        end
      end
    end
  end

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_owner <= -1; m_ptr <= 0; m_beats <= 0; m_stalls <= 0; m_xfer <= -1;
    end else begin
      m_owner <= n_owner; m_ptr <= n_ptr; m_beats <= n_beats;
      m_stalls <= n_stalls; m_xfer <= n_xfer;
    end
  end

  // Write / abort monitor
  always @(negedge clk_i) begin
    if (rst_ni && fifo_wr_en) wr_log.push_back(fifo_wdata);
    if (rst_ni && abort) abort_seen++;
  end

  // Driver tasks
  task automatic drive_inputs();
    for (int k = 0; k < NUM_REQ; k++) begin
      if (src_q[k].size() > 0 && !gap[k]) begin
        req_valid[k] = 1'b1;
        req_last[k] = src_q[k][0][WIDTH];
        req_data[k*WIDTH +: WIDTH] = src_q[k][0][WIDTH-1:0];
      end else begin
        req_valid[k] = 1'b0;
        req_last[k] = 1'($urandom_range(0, 1));
        req_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    #1;
    if (m_xfer >= 0 && src_q[m_xfer].size() > 0) void'(src_q[m_xfer].pop_front());
    drive_inputs();
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    fifo_full = 1'b0;
    gap = '0;
    for (int k = 0; k < NUM_REQ; k++) src_q[k].delete();
    drive_inputs();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    wr_log.delete();
    exp_q.delete();
    abort_seen = 0;
  endtask

  task automatic push_beats(input int k, input logic [WIDTH-1:0] base, input int n, input bit last_on_end);
    for (int i = 0; i < n; i++)
      src_q[k].push_back({(last_on_end && i == n - 1), WIDTH'(base + WIDTH'(i))});
  endtask

  // Scenarios
  task automatic test_reset();
    rst_ni = 1'b0;
    push_beats(0, 8'h01, 2, 1'b0);
    push_beats(3, 8'h02, 2, 1'b0);
    drive_inputs();
    repeat (5) begin
      @(negedge clk_i);
      checks++;
      if (act_vec !== '0) begin
        failures++;
        $display("FAIL reset_held got=%h exp=0", act_vec);
      end
    end
    rst_ni = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) src_q[k].delete();
    drive_inputs();
    repeat (10) begin
      cycle();
      @(negedge clk_i);
      checks++;
      if (act_vec !== '0 || exp_vec !== '0) begin
        failures++;
        $display("FAIL reset_idle got=%h exp=0", act_vec);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [WIDTH-1:0] a;
    apply_reset();
    push_beats(0, 8'h10, 12, 1'b0);
    push_beats(2, 8'h20, 12, 1'b0);
    drive_inputs();
    repeat (18) begin
      cycle();
      @(negedge clk_i);
      checks++;
      if (act_vec !== exp_vec) begin
        failures++;
        $display("FAIL rr_cycle t=%0t got=%h exp=%h", $time, act_vec, exp_vec);
      end
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(WIDTH'(8'h10 + i));
    for (int i = 0; i < 4; i++) exp_q.push_back(WIDTH'(8'h20 + i));
    for (int i = 0; i < 4; i++) exp_q.push_back(WIDTH'(8'h14 + i));
    while (exp_q.size() > 0) begin
      a = exp_q.pop_front();
      checks++;
      if (wr_log.size() == 0) begin
        failures++;
        $display("FAIL rr_data got=none exp=%h", a);
      end else if (wr_log[0] !== a) begin
        failures++;
        $display("FAIL rr_data got=%h exp=%h", wr_log[0], a);
        void'(wr_log.pop_front());
      end else void'(wr_log.pop_front());
    end
  endtask

  task automatic test_last();
    logic [WIDTH-1:0] a;
    apply_reset();
    push_beats(1, 8'hA0, 2, 1'b1);
    push_beats(3, 8'hB0, 3, 1'b1);
    drive_inputs();
    repeat (10) begin
      cycle();
      @(negedge clk_i);
      checks++;
      if (act_vec !== exp_vec) begin
        failures++;
        $display("FAIL last_cycle t=%0t got=%h exp=%h", $time, act_vec, exp_vec);
      end
    end
    exp_q = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hB2};
    checks++;
    if (wr_log.size() != 5) begin
      failures++;
      $display("FAIL last_count got=%0d exp=5", wr_log.size());
    end
    while (exp_q.size() > 0 && wr_log.size() > 0) begin
      a = exp_q.pop_front();
      checks++;
      if (wr_log[0] !== a) begin
        failures++;
        $display("FAIL last_data got=%h exp=%h", wr_log[0], a);
      end
      void'(wr_log.pop_front());
    end
  endtask

  task automatic test_backpressure();
    int writes_before;
    apply_reset();
    push_beats(0, 8'h40, 4, 1'b0);
    drive_inputs();
    repeat (3) cycle();
    fifo_full = 1'b1;
    writes_before = wr_log.size();
    repeat (20) begin
      @(negedge clk_i);
      checks++;
      if (act_vec !== exp_vec || fifo_wr_en !== 1'b0 || req_ready[0] !== 1'b0) begin
        failures++;
        $display("FAIL full_cycle t=%0t got=%h exp=%h", $time, act_vec, exp_vec);
      end
      cycle();
      fifo_full = 1'b1;
    end
    fifo_full = 1'b0;
    repeat (6) begin
      @(negedge clk_i);
      checks++;
      if (act_vec !== exp_vec) begin
        failures++;
        $display("FAIL full_resume t=%0t got=%h exp=%h", $time, act_vec, exp_vec);
      end
      cycle();
    end
    checks++;
    if (writes_before != 2 || abort_seen != 0) begin
      failures++;
      $display("FAIL full_stall writes_before=%0d aborts=%0d exp=2,0", writes_before, abort_seen);
    end
    exp_q = '{8'h40, 8'h41, 8'h42, 8'h43};
    checks++;
    if (wr_log != exp_q) begin
      failures++;
      $display("FAIL full_data got=%p exp=%p", wr_log, exp_q);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    push_beats(2, 8'h50, 1, 1'b0);
    push_beats(3, 8'h60, 2, 1'b1);
    drive_inputs();
    repeat (16) begin
      cycle();
      @(negedge clk_i);
      checks++;
      if (act_vec !== exp_vec) begin
        failures++;
        $display("FAIL timeout_cycle t=%0t got=%h exp=%h", $time, act_vec, exp_vec);
      end
    end
    checks++;
    if (abort_seen != 1) begin
      failures++;
      $display("FAIL timeout_abort got=%0d exp=1", abort_seen);
    end
    exp_q = '{8'h50, 8'h60, 8'h61};
    checks++;
    if (wr_log != exp_q) begin
      failures++;
      $display("FAIL timeout_data got=%p exp=%p", wr_log, exp_q);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    push_beats(0, 8'h30, 4, 1'b1);
    push_beats(1, 8'h70, 2, 1'b1);
    drive_inputs();
    repeat (3) cycle();
    #2;
    checks++;
    if (fifo_wr_en !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre wr_en=%b busy=%b exp=1,1", fifo_wr_en, busy);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if (act_vec !== '0) begin
      failures++;
      $display("FAIL arst_async got=%h exp=0", act_vec);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (10) begin
      cycle();
      @(negedge clk_i);
      checks++;
      if (act_vec !== exp_vec) begin
        failures++;
        $display("FAIL arst_cycle t=%0t got=%h exp=%h", $time, act_vec, exp_vec);
      end
    end
    exp_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h70, 8'h71};
    checks++;
    if (wr_log != exp_q) begin
      failures++;
      $display("FAIL arst_data got=%p exp=%p", wr_log, exp_q);
    end
  endtask

  task automatic test_random();
    apply_reset();
    repeat (1500) begin
      cycle();
      for (int k = 0; k < NUM_REQ; k++) begin
        if (src_q[k].size() < 3 && $urandom_range(0, 3) == 0)
          src_q[k].push_back({($urandom_range(0, 3) == 0), WIDTH'($urandom)});
        gap[k] = ($urandom_range(0, 9) == 0);
      end
      fifo_full = ($urandom_range(0, 4) == 0);
      drive_inputs();
      @(negedge clk_i);
      checks++;
      if (act_vec !== exp_vec) begin
        failures++;
        $display("FAIL rand_cycle t=%0t got=%h exp=%h", $time, act_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_last();
    test_backpressure();
    test_timeout();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the team's synchronous FIFO among NUM_REQ requesters.
- Each requester presents data with a valid/ready handshake. The winner holds the port for a burst that ends on last, on MAX_BURST beats, or on a stall timeout.
- Sits directly in front of the FIFO. Drives its wr_en/wdata and consumes its combinational full flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, data width; must equal the FIFO WIDTH.
- MAX_BURST, 4, maximum beats per grant (1..15).
- TIMEOUT, 8, consecutive owner-invalid cycles before forced release (1..15).
- IDX_WIDTH, 2, width of requester index; must be at least clog2(NUM_REQ).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester data valid.
- req_last_i  in  NUM_REQ  per-requester last beat of burst; qualified by valid.
- req_data_i  in  NUM_REQ*WIDTH  packed data; requester k occupies bits [k*WIDTH +: WIDTH].
- req_ready_o  out  NUM_REQ  per-requester ready; a beat transfers when valid and ready are both high.
- fifo_full_i  in  1  FIFO full flag.
- fifo_wr_en_o  out  1  FIFO write enable.
- fifo_wdata_o  out  WIDTH  FIFO write data.
- grant_o  out  NUM_REQ  one-hot current owner; all zero when idle.
- busy_o  out  1  high in BURST state.
- abort_o  out  1  one-cycle pulse on timeout release.

Behaviour:
- Reset is async on rst_ni low. While reset is asserted and after release:
  - state = IDLE, rr_ptr = 0, owner = 0, beat_cnt = 0, stall_cnt = 0.
  - All outputs are 0.
- Reset mid-burst abandons the burst immediately; no further writes occur.
- FSM has two states: IDLE and BURST.

IDLE:
- req_ready_o = 0, fifo_wr_en_o = 0.
- If any req_valid_i bit is set, owner <= first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- On that transition: beat_cnt <= 0, stall_cnt <= 0, state <= BURST.
- Arbitration costs exactly one bubble cycle per grant.

BURST (all outputs combinational from registered state and current inputs):
- req_ready_o[owner] = ~fifo_full_i; all other ready bits are 0.
- fifo_wr_en_o = req_valid_i[owner] & ~fifo_full_i.
- fifo_wdata_o = req_data_i slice of owner; it is 0 when fifo_wr_en_o is low.
- grant_o = one-hot(owner); busy_o = 1.

Beat accepted (fifo_wr_en_o = 1):
- beat_cnt increments and stall_cnt <= 0.
- If req_last_i[owner] = 1, or beat_cnt+1 == MAX_BURST:
  - state <= IDLE, rr_ptr <= owner+1 (wraps to 0 after NUM_REQ-1), beat_cnt <= 0.

Owner not valid:
- stall_cnt increments.
- When stall_cnt+1 == TIMEOUT:
  - abort_o = 1 for that cycle, state <= IDLE, rr_ptr <= owner+1.

Owner valid but fifo_fifo_full_i = 1:
- This is backpressure. No beat is written and stall_cnt holds; the timeout does not advance.
- The arbiter never asserts fifo_wr_en_o while fifo_full_i = 1, so the FIFO error flag must never fire because of this block.

Other rules:
- Non-owner requesters wait with ready = 0. Their data must be held stable by the requester; the arbiter does not latch it.
- A non-owner's last bit is ignored.
- Fairness: after any release, the previous owner has the lowest priority in the next arbitration.
- Counters are 4 bits wide. beat_cnt and stall_cnt never exceed MAX_BURST-1 and TIMEOUT-1 respectively.

Test Plan:
- Reset release, all valid = 0 for 10 cycles -> all outputs 0, state IDLE, no fifo_wr_en_o.
- Req0 and req2 valid continuously, no last, MAX_BURST = 4 -> req0 writes 4 beats (0x10..0x13), one bubble, then req2 writes 4 beats, one bubble, then req0 again. grant_o sequences 0001 -> 0100 -> 0001.
- Req1 sends 2 beats with last on the 2nd (0xA0, 0xA1) while req3 is also valid -> exactly 2 writes, release, then req3 is granted.
- fifo_full_i held high for 20 cycles during a req0 burst -> req_ready_o[0] = 0, no writes, no abort_o. When full drops, writing resumes with the pending beat.
- Owner req2 drops valid after 1 beat, TIMEOUT = 8 -> abort_o pulses once on the 8th invalid cycle, state returns to IDLE, and the next grant goes to req3 if it is valid.
- rst_ni asserted asynchronously mid-burst (after beat 2 of 4) -> fifo_wr_en_o, grant_o and busy_o go 0 without waiting for a clock edge. After release, arbitration restarts from req0.
